ccff_chain_loader: RTL
======================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 12, total configuration bits in the downstream ccff chain (range 1..4095).
REQ-002 SHALL have parameter WORD_W, default 8, width of each bitstream word accepted from the host (range 1..32).
REQ-003 SHALL have one clock and a synchronous, active-high reset: prog_clk input 1, the configuration clock; all state updates on its rising edge.
REQ-004 SHALL have prog_reset input 1, synchronous active-high reset.
REQ-005 SHALL have start input 1; a one-cycle pulse begins a chain load.
REQ-006 SHALL have abort input 1; terminates a load in progress.
REQ-007 SHALL have cfg_data input WORD_W, the bitstream word, MSB shifted first.
REQ-008 SHALL have cfg_valid input 1, host word valid.
REQ-009 SHALL have cfg_ready output 1, loader can accept a word.
REQ-010 SHALL have ccff_head output 1, serial bit driven into the chain head.
REQ-011 SHALL have ccff_tail input 1, serial bit returned from the chain tail.
REQ-012 SHALL have shift_en output 1, clock-gate enable for the chain's prog_clk; the chain advances one bit on every cycle it is high.
REQ-013 SHALL have busy output 1, high in LOAD.
REQ-014 SHALL have done output 1, one-cycle pulse on load completion.
REQ-015 SHALL have err output 1, sticky protocol-error flag.
REQ-016 SHALL have rb_ones output clog2(CHAIN_LEN+1), count of 1s received on ccff_tail during the last load.

Function
REQ-017 SHALL implement states IDLE, LOAD and DONE.
REQ-018 IDLE->LOAD on start; on that transition it SHALL clear bits_left to CHAIN_LEN, the shift register, and rb_ones.
REQ-019 In LOAD, cfg_ready SHALL be high when the shift register holds 0 bits, or exactly 1 bit that is being shifted this cycle, and bits_left > (bits held in the shift register).
REQ-020 A word SHALL be accepted only in a cycle where cfg_valid && cfg_ready; it is loaded with WORD_W valid bits.
REQ-021 Its MSB SHALL appear on ccff_head with shift_en=1 in the next cycle, for single-cycle latency.
REQ-022 Back-to-back valid words SHALL stream with no shift_en bubble.
REQ-023 Each cycle with shift register non-empty and bits_left>0: shift_en=1, ccff_head=current MSB, shift left, bits_left decrements by 1.
REQ-024 On that same edge, if ccff_tail=1 then rb_ones SHALL increment, saturating at CHAIN_LEN.
REQ-025 When the shift register is empty (host stall), shift_en=0 and ccff_head=0; the chain SHALL NOT advance.
REQ-026 If CHAIN_LEN is not a multiple of WORD_W, only the upper (CHAIN_LEN mod WORD_W) bits of the final word SHALL be shifted and the remaining low bits discarded.
REQ-027 No word SHALL be accepted once bits_left reaches 0.
REQ-028 When the last bit shifts (bits_left 1->0): next state DONE. DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-029 rb_ones SHALL hold its value until the next start.
REQ-030 A start while busy or in DONE SHALL be ignored and SHALL set err.
REQ-031 cfg_valid in IDLE SHALL be ignored, with no error.
REQ-032 abort in LOAD SHALL go to IDLE next cycle, deassert shift_en and cfg_ready immediately (same cycle, combinational), drop buffered bits, and produce no done pulse.
REQ-033 abort SHALL take precedence over a simultaneous handshake or shift.
REQ-034 A simultaneous start and abort in IDLE SHALL start the load.
REQ-035 err SHALL be cleared only by prog_reset.
REQ-036 shift_en and ccff_head SHALL be registered-state-derived, glitch-free (no combinational path from cfg_valid).

Reset
REQ-037 prog_reset SHALL give state=IDLE, cfg_ready=0, shift_en=0, ccff_head=0, busy=0, done=0, err=0, rb_ones=0, bits_left=0, shift register empty.
REQ-038 prog_reset SHALL override start, abort and handshake in the same cycle.
REQ-039 Reset mid-LOAD SHALL stop shifting on the next cycle, with no done pulse.

Verification
REQ-040 CHAIN_LEN=12, WORD_W=8; start, then words 0xA5,0xC0 continuously valid -> ccff_head over 12 shift_en cycles = 1,0,1,0,0,1,0,1,1,1,0,0; done one cycle after the 12th bit; second word's low 4 bits unused.
REQ-041 Same load with cfg_valid dropped for 3 cycles between words -> exactly 3 shift_en=0 bubbles; total shift_en-high cycles=12; bit order unchanged.
REQ-042 Chain model (12-bit shift register clocked by shift_en) preloaded 0xFFF, then load 0x00,0x00 -> rb_ones=12; the next load of 0xA5,0xC0 after a zero load -> rb_ones=0, and the chain holds the 12 bits of REQ-040.
REQ-043 abort after 5 shifted bits -> shift_en=0 that cycle; busy=0 next cycle; no done; a subsequent full load completes normally with 12 shifts.
REQ-044 start pulsed during LOAD -> err=1 and stays 1; load still completes with 12 shifts and done; prog_reset clears err.
REQ-045 prog_reset asserted mid-load with cfg_valid=1 -> all outputs reach their reset values after the reset edge; cfg_ready=0 until the next start.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// Host-side word stream into the ccff chain loader: data/valid from the host,
// ready back from the loader.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream words MSB-first into a configuration flip-flop chain
// and counts the 1s that fall out of the chain tail during the load.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 12,
  parameter int WORD_W    = 8
) (
  input  logic                               prog_clk,
  input  logic                               prog_reset,
  input  logic                               start,
  input  logic                               abort,
  ccff_chain_loader_if.slave                 cfg,
  output logic                               ccff_head,
  input  logic                               ccff_tail,
  output logic                               shift_en,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [$clog2(CHAIN_LEN+1)-1:0]     rb_ones
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int SC_W  = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] sreg;
  logic [SC_W-1:0]   sreg_cnt;
  logic [CNT_W-1:0]  bits_left;
  logic              shifting;
  logic              ready;
  logic              accept;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    shifting = 1'b0;
    ready    = 1'b0;
    if (state == S_LOAD && !abort) begin
      shifting = (sreg_cnt != '0) && (bits_left != '0);
      // A new word may land only when the buffer drains this cycle and the chain still wants more bits.
      ready    = ((sreg_cnt == '0) || (sreg_cnt == SC_W'(1) && shifting)) &&
                 (32'(bits_left) > 32'(sreg_cnt));
    end
    accept = ready && cfg.cfg_valid;
  end

  assign cfg.cfg_ready = ready;
  assign shift_en      = shifting;
  assign ccff_head     = shifting & sreg[WORD_W-1];
  assign busy          = (state == S_LOAD);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= S_IDLE;
      sreg      <= '0;
      sreg_cnt  <= '0;
      bits_left <= '0;
      rb_ones   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start together with abort still launches the load; host words are ignored here.
          if (start) begin
            state     <= S_LOAD;
            bits_left <= CNT_W'(CHAIN_LEN);
            sreg      <= '0;
            sreg_cnt  <= '0;
            rb_ones   <= '0;
          end
        end

        S_LOAD: begin
          if (start) err <= 1'b1;
          if (abort) begin
            state     <= S_IDLE;
            sreg      <= '0;
            sreg_cnt  <= '0;
            bits_left <= '0;
          end else begin
            if (shifting) begin
              sreg      <= sreg << 1;
              sreg_cnt  <= sreg_cnt - SC_W'(1);
              bits_left <= bits_left - CNT_W'(1);
              if (ccff_tail && rb_ones != CNT_W'(CHAIN_LEN)) rb_ones <= rb_ones + CNT_W'(1);
              // Last chain bit: leftover low bits of a partial final word are dropped.
              if (bits_left == CNT_W'(1)) begin
                state    <= S_DONE;
                done     <= 1'b1;
                sreg     <= '0;
                sreg_cnt <= '0;
              end
            end
            if (accept) begin
              sreg     <= cfg.cfg_data;
              sreg_cnt <= SC_W'(WORD_W);
            end
          end
        end

        S_DONE: begin
          if (start) err <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
